// File: rtl/lstm_gate_matvec_if.sv
// rtl/lstm_gate_matvec_if.sv - control, weight stream, RAM and result bundle for the gate mat-vec engine
interface lstm_gate_matvec_if #(
  parameter int GATES    = 4,
  parameter int MAX_ROWS = 512,
  parameter int MAX_COLS = 512,
  parameter int DATA_W   = 16,
  parameter int W_W      = 8,
  parameter int OUT_W    = 16
);
  localparam int RW = $clog2(MAX_ROWS);
  localparam int CW = $clog2(MAX_COLS);

  logic                   start;
  logic                   abort;
  logic [RW:0]            cfg_rows;
  logic [CW:0]            cfg_cols;
  logic                   cfg_bias_en;
  logic [GATES*W_W-1:0]   w_data;
  logic                   w_valid;
  logic                   w_ready;
  logic                   h_rd_en;
  logic [CW-1:0]          h_rd_addr;
  logic [DATA_W-1:0]      h_rd_data;
  logic                   b_rd_en;
  logic [RW-1:0]          b_rd_addr;
  logic [GATES*OUT_W-1:0] b_rd_data;
  logic [GATES*OUT_W-1:0] out_data;
  logic [RW-1:0]          out_row;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   done;
  logic                   sat_flag;

  modport master (
    output start, abort, cfg_rows, cfg_cols, cfg_bias_en, w_data, w_valid,
           h_rd_data, b_rd_data, out_ready,
    input  w_ready, h_rd_en, h_rd_addr, b_rd_en, b_rd_addr, out_data, out_row,
           out_valid, busy, done, sat_flag
  );

  modport slave (
    input  start, abort, cfg_rows, cfg_cols, cfg_bias_en, w_data, w_valid,
           h_rd_data, b_rd_data, out_ready,
    output w_ready, h_rd_en, h_rd_addr, b_rd_en, b_rd_addr, out_data, out_row,
           out_valid, busy, done, sat_flag
  );
endinterface

// File: rtl/lstm_gate_matvec.sv
// rtl/lstm_gate_matvec.sv - streaming multi-gate matrix-vector engine for the LSTM recurrent path
module lstm_gate_matvec #(
  parameter int GATES    = 4,
  parameter int MAX_ROWS = 512,
  parameter int MAX_COLS = 512,
  parameter int DATA_W   = 16,
  parameter int W_W      = 8,
  parameter int OUT_W    = 16,
  parameter int FRAC_SH  = 8,
  parameter int ACC_W    = DATA_W + W_W + $clog2(MAX_COLS)
) (
  input logic               i_clk,
  input logic               i_rst,
  lstm_gate_matvec_if.slave bus
);
  localparam int RW = $clog2(MAX_ROWS);
  localparam int CW = $clog2(MAX_COLS);
  localparam int PW = DATA_W + W_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_MAC, S_DRAIN, S_OUT, S_DONE} state_t;

  state_t                  r_state;
  logic [RW:0]             r_rows;
  logic [CW:0]             r_cols;
  logic                    r_bias_en;
  logic [RW-1:0]           r_row;
  logic [CW-1:0]           r_col;
  logic                    r_drain2;
  logic                    r_w_ready;
  logic                    r_out_valid;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_sat;
  logic [GATES*OUT_W-1:0]  r_out_data;
  logic [RW-1:0]           r_out_row;
  logic                    r_h_pend;
  logic                    r_seed_pend;
  logic                    r_prod_v;
  logic signed [DATA_W-1:0] r_h;
  logic signed [PW-1:0]    r_prod [GATES];
  logic signed [ACC_W-1:0] r_acc [GATES];

  logic                    w_accept;
  logic                    w_last_col;
  logic                    w_last_row;
  logic signed [DATA_W-1:0] w_h_cur;
  logic signed [ACC_W-1:0] w_shift [GATES];
  logic [GATES*OUT_W-1:0]  w_sat_data;
  logic                    w_sat_any;

  assign w_accept   = r_w_ready && bus.w_valid;
  assign w_last_col = ({1'b0, r_col} == r_cols - (CW+1)'(1));
  assign w_last_row = ({1'b0, r_row} == r_rows - (RW+1)'(1));
  // h[c] is either arriving from the RAM this cycle or parked in r_h during a stall
  assign w_h_cur    = r_h_pend ? $signed(bus.h_rd_data) : r_h;

  // The next column is fetched in the same cycle a beat is taken so one beat per cycle is sustained
  assign bus.h_rd_en   = (r_state == S_PRIME) || (w_accept && !w_last_col);
  assign bus.h_rd_addr = (r_state == S_PRIME) ? '0 : r_col + CW'(1);
  assign bus.b_rd_en   = (r_state == S_PRIME) && r_bias_en;
  assign bus.b_rd_addr = r_row;

  assign bus.w_ready   = r_w_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_row   = r_out_row;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sat_flag  = r_sat;

  // Scale each lane accumulator down and clamp it into the output width
  always_comb begin
    w_sat_any  = 1'b0;
    w_sat_data = '0;
    for (int g = 0; g < GATES; g++) begin
      w_shift[g] = r_acc[g] >>> FRAC_SH;
      if (w_shift[g] > SAT_MAX) begin
        w_sat_data[g*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
        w_sat_any = 1'b1;
      end else if (w_shift[g] < SAT_MIN) begin
        w_sat_data[g*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
        w_sat_any = 1'b1;
      end else begin
        w_sat_data[g*OUT_W +: OUT_W] = w_shift[g][OUT_W-1:0];
      end
    end
  end

  // Track in-flight RAM reads and products; abort drops them so nothing stale is used later
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h_pend    <= 1'b0;
      r_seed_pend <= 1'b0;
      r_prod_v    <= 1'b0;
      r_h         <= '0;
    end else begin
      if (r_h_pend) r_h <= $signed(bus.h_rd_data);
      if (bus.abort) begin
        r_h_pend    <= 1'b0;
        r_seed_pend <= 1'b0;
        r_prod_v    <= 1'b0;
      end else begin
        r_h_pend    <= bus.h_rd_en;
        r_seed_pend <= bus.b_rd_en;
        r_prod_v    <= w_accept;
      end
    end
  end

  // One registered signed product per lane for every accepted beat
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int g = 0; g < GATES; g++) r_prod[g] <= '0;
    end else if (w_accept) begin
      for (int g = 0; g < GATES; g++)
        r_prod[g] <= PW'($signed(bus.w_data[g*W_W +: W_W])) * PW'(w_h_cur);
    end
  end

  // Row accumulators: cleared in PRIME, seeded from the bias word when it lands, then summed
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int g = 0; g < GATES; g++) r_acc[g] <= '0;
    end else if (r_state == S_PRIME) begin
      for (int g = 0; g < GATES; g++) r_acc[g] <= '0;
    end else if (r_seed_pend) begin
      for (int g = 0; g < GATES; g++)
        r_acc[g] <= ACC_W'($signed(bus.b_rd_data[g*OUT_W +: OUT_W])) <<< FRAC_SH;
    end else if (r_prod_v) begin
      for (int g = 0; g < GATES; g++) r_acc[g] <= r_acc[g] + ACC_W'(r_prod[g]);
    end
  end

  // Run sequencing: row/column counters, handshakes and status flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rows      <= '0;
      r_cols      <= '0;
      r_bias_en   <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_drain2    <= 1'b0;
      r_w_ready   <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sat       <= 1'b0;
      r_out_data  <= '0;
      r_out_row   <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state     <= S_IDLE;
        r_row       <= '0;
        r_col       <= '0;
        r_drain2    <= 1'b0;
        r_w_ready   <= 1'b0;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_rows    <= bus.cfg_rows;
              r_cols    <= bus.cfg_cols;
              r_bias_en <= bus.cfg_bias_en;
              r_row     <= '0;
              r_col     <= '0;
              r_sat     <= 1'b0;
              r_busy    <= 1'b1;
              if (bus.cfg_rows == '0 || bus.cfg_cols == '0) r_state <= S_DONE;
              else                                          r_state <= S_PRIME;
            end
          end
          S_PRIME: begin
            r_w_ready <= 1'b1;
            r_state   <= S_MAC;
          end
          S_MAC: begin
            if (w_accept) begin
              if (w_last_col) begin
                r_col     <= '0;
                r_w_ready <= 1'b0;
                r_drain2  <= 1'b0;
                r_state   <= S_DRAIN;
              end else begin
                r_col <= r_col + CW'(1);
              end
            end
          end
          S_DRAIN: begin
            if (!r_drain2) begin
              r_drain2 <= 1'b1;
            end else begin
              r_drain2    <= 1'b0;
              r_out_data  <= w_sat_data;
              r_out_row   <= r_row;
              r_out_valid <= 1'b1;
              if (w_sat_any) r_sat <= 1'b1;
              r_state     <= S_OUT;
            end
          end
          S_OUT: begin
            if (bus.out_ready) begin
              r_out_valid <= 1'b0;
              if (w_last_row) begin
                r_row   <= '0;
                r_state <= S_DONE;
              end else begin
                r_row   <= r_row + RW'(1);
                r_state <= S_PRIME;
              end
            end
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
